// File: rtl/pipeline_hazard_controller_if.sv
// Pipeline-side bundle for the hazard controller: stage status toward the controller,
// latch/PC enables, flushes and performance counters back to the pipeline.
interface pipeline_hazard_controller_if #(
  parameter int CNT_W = 32,
  parameter int REG_W = 4
);
  logic             of_valid;
  logic [REG_W-1:0] of_rs1;
  logic [REG_W-1:0] of_rs2;
  logic             of_uses_rs1;
  logic             of_uses_rs2;
  logic             of_is_halt;
  logic             ex_valid;
  logic             ma_valid;
  logic             wb_valid;
  logic [REG_W-1:0] ex_rd;
  logic [REG_W-1:0] ma_rd;
  logic [REG_W-1:0] wb_rd;
  logic             ex_is_wb;
  logic             ma_is_wb;
  logic             wb_is_wb;
  logic             ex_is_branch_taken;
  logic             resume;

  logic             pc_en;
  logic             if_of_en;
  logic             if_of_flush;
  logic             of_ex_flush;
  logic             halted;
  logic [CNT_W-1:0] cycle_count;
  logic [CNT_W-1:0] retire_count;
  logic [CNT_W-1:0] stall_count;

  modport master (
    output of_valid, of_rs1, of_rs2, of_uses_rs1, of_uses_rs2, of_is_halt,
    output ex_valid, ma_valid, wb_valid, ex_rd, ma_rd, wb_rd,
    output ex_is_wb, ma_is_wb, wb_is_wb, ex_is_branch_taken, resume,
    input  pc_en, if_of_en, if_of_flush, of_ex_flush, halted,
    input  cycle_count, retire_count, stall_count
  );

  modport slave (
    input  of_valid, of_rs1, of_rs2, of_uses_rs1, of_uses_rs2, of_is_halt,
    input  ex_valid, ma_valid, wb_valid, ex_rd, ma_rd, wb_rd,
    input  ex_is_wb, ma_is_wb, wb_is_wb, ex_is_branch_taken, resume,
    output pc_en, if_of_en, if_of_flush, of_ex_flush, halted,
    output cycle_count, retire_count, stall_count
  );
endinterface

// File: rtl/pipeline_hazard_controller.sv
// RAW-hazard stall, taken-branch flush and halt/drain/resume sequencing for a
// forwarding-less 5-stage pipeline; controls are combinational, state/counters registered.
module pipeline_hazard_controller #(
  parameter int CNT_W = 32,
  parameter int REG_W = 4
) (
  input logic                         clk,
  input logic                         reset_n,
  pipeline_hazard_controller_if.slave bus
);

  typedef enum logic [1:0] {RUN, DRAIN, HALTED} state_t;

  state_t           state_q, state_d;
  logic [1:0]       drain_q, drain_d;
  logic             halted_q;
  logic [CNT_W-1:0] cycle_q, retire_q, stall_q;
  logic             cycle_inc, stall_inc;

  logic [REG_W-1:0] rs1, rs2;
  logic             hit_rs1, hit_rs2, hz, br;

  assign rs1 = bus.of_rs1;
  assign rs2 = bus.of_rs2;

  // WB producers still count: the register file writes at the same edge OF would advance.
  assign hit_rs1 = (bus.ex_valid & bus.ex_is_wb & (bus.ex_rd == rs1)) |
                   (bus.ma_valid & bus.ma_is_wb & (bus.ma_rd == rs1)) |
                   (bus.wb_valid & bus.wb_is_wb & (bus.wb_rd == rs1));
  assign hit_rs2 = (bus.ex_valid & bus.ex_is_wb & (bus.ex_rd == rs2)) |
                   (bus.ma_valid & bus.ma_is_wb & (bus.ma_rd == rs2)) |
                   (bus.wb_valid & bus.wb_is_wb & (bus.wb_rd == rs2));
  assign hz = bus.of_valid & ((bus.of_uses_rs1 & hit_rs1) | (bus.of_uses_rs2 & hit_rs2));
  assign br = bus.ex_valid & bus.ex_is_branch_taken;

  always_comb begin
    state_d         = state_q;
    drain_d         = drain_q;
    bus.pc_en       = 1'b0;
    bus.if_of_en    = 1'b0;
    bus.if_of_flush = 1'b0;
    bus.of_ex_flush = 1'b1;
    cycle_inc       = 1'b0;
    stall_inc       = 1'b0;
    if (!reset_n) begin
      bus.if_of_flush = 1'b1;
    end else begin
      case (state_q)
        RUN: begin
          cycle_inc = 1'b1;
          if (br) begin
            bus.pc_en       = 1'b1;
            bus.if_of_en    = 1'b1;
            bus.if_of_flush = 1'b1;
          end else if (hz) begin
            stall_inc = 1'b1;
          end else if (bus.of_valid && bus.of_is_halt) begin
            // PC stays put so a later resume refetches the instruction after the halt.
            bus.if_of_en    = 1'b1;
            bus.if_of_flush = 1'b1;
            state_d         = DRAIN;
            drain_d         = 2'd3;
          end else begin
            bus.pc_en       = 1'b1;
            bus.if_of_en    = 1'b1;
            bus.of_ex_flush = 1'b0;
          end
        end
        DRAIN: begin
          cycle_inc = 1'b1;
          drain_d   = drain_q - 2'd1;
          if (drain_q == 2'd1) state_d = HALTED;
        end
        HALTED: begin
          if (bus.resume) state_d = RUN;
        end
        default: state_d = RUN;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q  <= RUN;
      drain_q  <= 2'd0;
      halted_q <= 1'b0;
      cycle_q  <= '0;
      retire_q <= '0;
      stall_q  <= '0;
    end else begin
      state_q  <= state_d;
      drain_q  <= drain_d;
      halted_q <= (state_d == HALTED);
      if (cycle_inc && (cycle_q != '1))     cycle_q  <= cycle_q + 1'b1;
      if (bus.wb_valid && (retire_q != '1)) retire_q <= retire_q + 1'b1;
      if (stall_inc && (stall_q != '1))     stall_q  <= stall_q + 1'b1;
    end
  end

  assign bus.halted       = halted_q;
  assign bus.cycle_count  = cycle_q;
  assign bus.retire_count = retire_q;
  assign bus.stall_count  = stall_q;

endmodule

// File: tb/tb_pipeline_hazard_controller.sv
// Scoreboard bench: directed scenarios then random traffic, checked against a behavioural model.
module tb_pipeline_hazard_controller;

  logic clk = 1'b0;
  logic reset_n;
  always #5 clk = ~clk;

  pipeline_hazard_controller_if #(.CNT_W(32), .REG_W(4)) bus ();
  pipeline_hazard_controller_if #(.CNT_W(4),  .REG_W(4)) bus_s ();

  pipeline_hazard_controller #(.CNT_W(32), .REG_W(4)) dut (
    .clk(clk), .reset_n(reset_n), .bus(bus.slave));
  pipeline_hazard_controller #(.CNT_W(4), .REG_W(4)) dut_s (
    .clk(clk), .reset_n(reset_n), .bus(bus_s.slave));

  assign bus_s.of_valid           = bus.of_valid;
  assign bus_s.of_rs1             = bus.of_rs1;
  assign bus_s.of_rs2             = bus.of_rs2;
  assign bus_s.of_uses_rs1        = bus.of_uses_rs1;
  assign bus_s.of_uses_rs2        = bus.of_uses_rs2;
  assign bus_s.of_is_halt         = bus.of_is_halt;
  assign bus_s.ex_valid           = bus.ex_valid;
  assign bus_s.ma_valid           = bus.ma_valid;
  assign bus_s.wb_valid           = bus.wb_valid;
  assign bus_s.ex_rd              = bus.ex_rd;
  assign bus_s.ma_rd              = bus.ma_rd;
  assign bus_s.wb_rd              = bus.wb_rd;
  assign bus_s.ex_is_wb           = bus.ex_is_wb;
  assign bus_s.ma_is_wb           = bus.ma_is_wb;
  assign bus_s.wb_is_wb           = bus.wb_is_wb;
  assign bus_s.ex_is_branch_taken = bus.ex_is_branch_taken;
  assign bus_s.resume             = bus.resume;

  // Stage index 0=EX, 1=MA, 2=WB; rd packs the three destinations.
  typedef struct packed {
    logic        rst_n;
    logic        of_valid;
    logic [3:0]  rs1, rs2;
    logic        u1, u2, halt;
    logic [2:0]  v, w;
    logic [11:0] rd;
    logic        br, resume;
  } in_t;

  typedef struct packed {
    logic        pc_en, if_of_en, if_of_flush, of_ex_flush, halted;
    logic [31:0] cyc, ret, stl;
    logic [3:0]  cyc_s, ret_s, stl_s;
  } exp_t;

  exp_t sb[$];
  int   tests = 0;
  int   fails = 0;

  // Model: mode 0=running, 1=draining, 2=halted; counts are raw event totals.
  int     mode = 0;
  int     left = 0;
  longint n_cyc = 0, n_ret = 0, n_stl = 0;
  in_t    cur;

  function automatic in_t idle();
    in_t t;
    t = '0;
    t.rst_n = 1'b1;
    return t;
  endfunction

  function automatic bit has_hazard(in_t s);
    bit m1 = 0, m2 = 0;
    for (int i = 0; i < 3; i++) begin
      if (s.v[i] && s.w[i]) begin
        if (s.rd[4*i +: 4] == s.rs1) m1 = 1;
        if (s.rd[4*i +: 4] == s.rs2) m2 = 1;
      end
    end
    return s.of_valid && ((s.u1 && m1) || (s.u2 && m2));
  endfunction

  function automatic longint sat(longint n, int w);
    longint mx = (64'sd1 <<< w) - 1;
    return (n > mx) ? mx : n;
  endfunction

  task automatic commit(in_t s);
    bit br_now = s.v[0] && s.br;
    if (!s.rst_n) begin
      mode = 0; left = 0; n_cyc = 0; n_ret = 0; n_stl = 0;
      return;
    end
    if (mode == 0) begin
      n_cyc++;
      if (!br_now) begin
        if (has_hazard(s)) n_stl++;
        else if (s.of_valid && s.halt) begin mode = 1; left = 3; end
      end
    end else if (mode == 1) begin
      n_cyc++;
      left--;
      if (left == 0) mode = 2;
    end else if (s.resume) begin
      mode = 0;
    end
    if (s.v[2]) n_ret++;
  endtask

  function automatic exp_t expect_for(in_t s);
    exp_t e;
    e = '0;
    e.halted = (mode == 2);
    e.cyc = 32'(sat(n_cyc, 32)); e.ret = 32'(sat(n_ret, 32)); e.stl = 32'(sat(n_stl, 32));
    e.cyc_s = 4'(sat(n_cyc, 4)); e.ret_s = 4'(sat(n_ret, 4)); e.stl_s = 4'(sat(n_stl, 4));
    if (!s.rst_n)                         {e.pc_en, e.if_of_en, e.if_of_flush, e.of_ex_flush} = 4'b0011;
    else if (mode != 0)                   {e.pc_en, e.if_of_en, e.if_of_flush, e.of_ex_flush} = 4'b0001;
    else if (s.v[0] && s.br)              {e.pc_en, e.if_of_en, e.if_of_flush, e.of_ex_flush} = 4'b1111;
    else if (has_hazard(s))               {e.pc_en, e.if_of_en, e.if_of_flush, e.of_ex_flush} = 4'b0001;
    else if (s.of_valid && s.halt)        {e.pc_en, e.if_of_en, e.if_of_flush, e.of_ex_flush} = 4'b0111;
    else                                  {e.pc_en, e.if_of_en, e.if_of_flush, e.of_ex_flush} = 4'b1100;
    return e;
  endfunction

  task automatic apply(in_t s);
    reset_n = s.rst_n;
    bus.of_valid = s.of_valid; bus.of_rs1 = s.rs1; bus.of_rs2 = s.rs2;
    bus.of_uses_rs1 = s.u1; bus.of_uses_rs2 = s.u2; bus.of_is_halt = s.halt;
    bus.ex_valid = s.v[0]; bus.ma_valid = s.v[1]; bus.wb_valid = s.v[2];
    bus.ex_is_wb = s.w[0]; bus.ma_is_wb = s.w[1]; bus.wb_is_wb = s.w[2];
    bus.ex_rd = s.rd[3:0]; bus.ma_rd = s.rd[7:4]; bus.wb_rd = s.rd[11:8];
    bus.ex_is_branch_taken = s.br; bus.resume = s.resume;
  endtask

  task automatic step(in_t s);
    @(posedge clk);
    #1;
    commit(cur);
    cur = s;
    apply(s);
    sb.push_back(expect_for(s));
  endtask

  task automatic check(string name, longint act, longint exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (sb.size() > 0) begin
      exp_t e;
      e = sb.pop_front();
      check("pc_en",        bus.pc_en,          e.pc_en);
      check("if_of_en",     bus.if_of_en,       e.if_of_en);
      check("if_of_flush",  bus.if_of_flush,    e.if_of_flush);
      check("of_ex_flush",  bus.of_ex_flush,    e.of_ex_flush);
      check("halted",       bus.halted,         e.halted);
      check("cycle_count",  bus.cycle_count,    e.cyc);
      check("retire_count", bus.retire_count,   e.ret);
      check("stall_count",  bus.stall_count,    e.stl);
      check("cycle_count4", bus_s.cycle_count,  e.cyc_s);
      check("retire_count4",bus_s.retire_count, e.ret_s);
      check("stall_count4", bus_s.stall_count,  e.stl_s);
      check("halted4",      bus_s.halted,       e.halted);
    end
  end

  initial begin
    in_t t;
    cur = idle();
    cur.rst_n = 1'b0;
    apply(cur);

    // Reset for two cycles, then idle.
    t = idle(); t.rst_n = 1'b0;
    step(t); step(t);
    t = idle();
    repeat (6) step(t);

    // Producer of r3 walks EX -> MA -> WB while OF reads r3.
    t = idle(); t.of_valid = 1; t.rs1 = 4'd3; t.u1 = 1; t.rs2 = 4'd9; t.u2 = 1;
    t.v = 3'b001; t.w = 3'b001; t.rd = {4'd0, 4'd0, 4'd3}; step(t);
    t.v = 3'b010; t.w = 3'b010; t.rd = {4'd0, 4'd3, 4'd0}; step(t);
    t.v = 3'b100; t.w = 3'b100; t.rd = {4'd3, 4'd0, 4'd0}; step(t);
    t.v = 3'b000; t.w = 3'b000; step(t);
    step(idle());

    // Hazard on r5 in the same cycle EX resolves a taken branch.
    t = idle(); t.of_valid = 1; t.rs2 = 4'd5; t.u2 = 1;
    t.v = 3'b001; t.w = 3'b001; t.rd = {4'd0, 4'd0, 4'd5}; t.br = 1; step(t);
    // Halt in OF alongside a taken branch: no drain.
    t = idle(); t.of_valid = 1; t.halt = 1; t.v = 3'b001; t.br = 1; step(t);
    step(idle());

    // Halt with three older instructions in flight.
    t = idle(); t.of_valid = 1; t.halt = 1;
    t.v = 3'b111; t.w = 3'b111; t.rd = {4'd1, 4'd2, 4'd4}; step(t);
    t = idle(); t.v = 3'b110; t.w = 3'b110; t.rd = {4'd2, 4'd4, 4'd0}; step(t);
    t = idle(); t.v = 3'b100; t.w = 3'b100; t.rd = {4'd4, 4'd0, 4'd0}; step(t);
    t = idle(); t.br = 1; t.of_valid = 1; t.rs1 = 4'd4; t.u1 = 1; step(t);
    repeat (4) step(idle());
    t = idle(); t.resume = 1; t.rst_n = 1'b0; step(t);
    t = idle(); t.of_valid = 1; t.halt = 1; step(t);
    repeat (4) step(idle());
    t = idle(); t.resume = 1; step(t);
    repeat (3) step(idle());

    // Reset while draining with two drain cycles left.
    t = idle(); t.of_valid = 1; t.halt = 1; step(t);
    step(idle());
    t = idle(); t.rst_n = 1'b0; step(t);
    repeat (2) step(idle());

    // Retire every cycle past narrow-counter saturation; resume pulses outside HALTED.
    t = idle(); t.v = 3'b100; t.resume = 1;
    repeat (20) step(t);

    // Random traffic with small register range to provoke hazards.
    for (int i = 0; i < 3000; i++) begin
      t.rst_n    = ($urandom_range(0, 99) != 0);
      t.of_valid = ($urandom_range(0, 3) != 0);
      t.rs1      = 4'($urandom_range(0, 3));
      t.rs2      = 4'($urandom_range(0, 3));
      t.u1       = 1'($urandom);
      t.u2       = 1'($urandom);
      t.halt     = ($urandom_range(0, 11) == 0);
      t.v        = 3'($urandom);
      t.w        = 3'($urandom);
      t.rd       = {4'($urandom_range(0, 5)), 4'($urandom_range(0, 5)), 4'($urandom_range(0, 5))};
      t.br       = ($urandom_range(0, 5) == 0);
      t.resume   = ($urandom_range(0, 5) == 0);
      step(t);
    end

    repeat (3) @(negedge clk);
    tests++;
    if (sb.size() != 0) begin
      fails++;
      $display("FAIL scoreboard_drain: %0d entries left, expected 0", sb.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
